// File: rtl/mm2x2_host_seq_pkg.sv
// Shared frame timing, slot map and result-word layout for the 2x2 matrix-multiply host sequencer.
package mm2x2_host_seq_pkg;

   localparam int FRAME_LEN  = 13;
   localparam int LANE_BYTES = 4;
   localparam int JOB_BYTES  = 2 * LANE_BYTES;

   typedef logic [3:0] slot_t;

   localparam slot_t LAST_SLOT = slot_t'(FRAME_LEN - 1);
   localparam slot_t A_FIRST   = 4'd0;
   localparam slot_t B_FIRST   = 4'd4;
   localparam slot_t C00_SLOT  = 4'd10;
   localparam slot_t C01_SLOT  = 4'd11;
   localparam slot_t C10_SLOT  = 4'd12;
   localparam slot_t C11_SLOT  = 4'd0;

   // First field lands in the most significant byte of the result word.
   typedef struct packed {
      logic [7:0] c00;
      logic [7:0] c01;
      logic [7:0] c10;
      logic [7:0] c11;
   } res_word_t;

   function automatic res_word_t pack_result(input logic [7:0] c00, input logic [7:0] c01,
                                             input logic [7:0] c10, input logic [7:0] c11);
      res_word_t w;
      w.c00 = c00;
      w.c01 = c01;
      w.c10 = c10;
      w.c11 = c11;
      return w;
   endfunction

endpackage

// File: rtl/mm2x2_res_fifo.sv
// Small show-ahead result FIFO: head entry is always visible on head_data.
module mm2x2_res_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mm2x2_host_seq.sv
// Host sequencer for the 2x2 serial matrix-multiply tile: stages operand bytes, drives them
// in lock-step with the tile's 13-cycle frame and collects the four result bytes into a word.
module mm2x2_host_seq
   import mm2x2_host_seq_pkg::*;
#(
   parameter int RES_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic [7:0]  mm_a,
   output logic [7:0]  mm_b,
   input  logic [7:0]  mm_c,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        busy
);

   localparam int FCW = $clog2(RES_DEPTH + 1);

   slot_t           slot_q, slot_d;
   logic [3:0]      count_q, count_d;
   logic [7:0][7:0] stage_q, stage_d;
   logic [7:0][7:0] drive_q, drive_d;
   logic            live_q, live_d;
   logic            pend_q, pend_d;
   logic [7:0]      c00_q, c00_d;
   logic [7:0]      c01_q, c01_d;
   logic [7:0]      c10_q, c10_d;

   logic            in_fire;
   logic            pop_now;
   logic            push_now;
   logic            inflight;
   logic            launch;
   logic [FCW-1:0]  fifo_count;
   logic [FCW:0]    credit_used;
   logic            fifo_empty;
   res_word_t       push_word;
   slot_t           a_rel;
   slot_t           b_rel;

   assign in_ready  = (count_q != 4'(JOB_BYTES));
   assign in_fire   = in_valid & in_ready;
   assign res_valid = ~fifo_empty;
   assign pop_now   = res_valid & res_ready;
   assign inflight  = live_q | pend_q;
   assign busy      = (count_q != '0) | live_q | pend_q | ~fifo_empty;

   // A frame may only start if its result and the one still in flight both have a FIFO slot.
   assign credit_used = {1'b0, fifo_count} + (FCW+1)'(inflight);
   assign launch      = (slot_q == LAST_SLOT) && !in_ready &&
                        (credit_used < (FCW+1)'(RES_DEPTH) + (FCW+1)'(pop_now));

   // C11 of the previous frame is on the lane during slot 0, while the next frame may be live.
   assign push_now  = pend_q && (slot_q == C11_SLOT);
   assign push_word = pack_result(c00_q, c01_q, c10_q, mm_c);

   always_comb begin
      slot_d  = (slot_q == LAST_SLOT) ? '0 : slot_q + slot_t'(1);
      count_d = count_q;
      stage_d = stage_q;
      drive_d = drive_q;
      live_d  = live_q;
      pend_d  = pend_q;
      c00_d   = c00_q;
      c01_d   = c01_q;
      c10_d   = c10_q;

      if (in_fire) begin
         stage_d[count_q[2:0]] = in_data;
         count_d               = count_q + 4'd1;
      end

      if (live_q) begin
         case (slot_q)
            C00_SLOT: c00_d = mm_c;
            C01_SLOT: c01_d = mm_c;
            C10_SLOT: c10_d = mm_c;
            default:  ;
         endcase
      end

      if (slot_q == LAST_SLOT) begin
         live_d = launch;
         pend_d = live_q;
         if (launch) begin
            drive_d = stage_q;
            count_d = '0;
         end
      end

      if (push_now) begin
         pend_d = 1'b0;
      end
   end

   always_comb begin
      a_rel = slot_q - A_FIRST;
      b_rel = slot_q - B_FIRST;
      mm_a  = '0;
      mm_b  = '0;
      if (live_q && a_rel < slot_t'(LANE_BYTES)) begin
         mm_a = drive_q[{1'b0, a_rel[1:0]}];
      end
      if (live_q && b_rel < slot_t'(LANE_BYTES)) begin
         mm_b = drive_q[{1'b1, b_rel[1:0]}];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q  <= '0;
         count_q <= '0;
         stage_q <= '0;
         drive_q <= '0;
         live_q  <= 1'b0;
         pend_q  <= 1'b0;
         c00_q   <= '0;
         c01_q   <= '0;
         c10_q   <= '0;
      end else begin
         slot_q  <= slot_d;
         count_q <= count_d;
         stage_q <= stage_d;
         drive_q <= drive_d;
         live_q  <= live_d;
         pend_q  <= pend_d;
         c00_q   <= c00_d;
         c01_q   <= c01_d;
         c10_q   <= c10_d;
      end
   end

   mm2x2_res_fifo #(
      .DEPTH (RES_DEPTH),
      .WIDTH (32)
   ) u_res_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_now),
      .push_data (push_word),
      .pop       (pop_now),
      .head_data (res_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

endmodule
